riscv_mem_loader: RTL and testbench

Upstream boot/launch stage for the RISC-V Lite DataPath. Accepts a valid/ready word stream, writes the program segment then the data segment into the DataPath's instruction and data memories through its LOAD_PROGRAM_* and LOAD_DATA_* ports, and then releases the core with reset, EN and START. It counts cycles until the core raises OK, which replaces the bench-side loading and CPI measurement in hardware.

---
 rtl/riscv_mem_loader.sv | 262 ++++++++++++++++++++++++++
 tb/tb_riscv_mem_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_loader.sv
// rtl/riscv_mem_loader.sv - boot loader that streams program/data words into the RISC-V Lite DataPath memories and times the run
//
// Purpose:
//   Accepts a valid/ready word stream. The first segment, up to IN_LAST, goes to
//   instruction memory. The second segment goes to data memory. The loader then
//   releases the core and counts cycles until the core raises CPU_OK.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   GO                  start-load pulse (honoured in IDLE/DONE/ERROR only)
//   IN_VALID/IN_READY   stream handshake; IN_DATA word, IN_LAST ends a segment
//   LOAD_PROGRAM_*      instruction-memory write port (CTRL = write enable)
//   LOAD_DATA_*         data-memory write port (CTRL = write enable)
//   CPU_RSTn/EN/START   core control; CPU_OK is the core's completion flag
//   CYCLE_COUNT         saturating run-cycle counter
//   PROG_WORDS          program-memory words written, pad words included
//   DATA_WORDS          data-memory words written
//   BUSY, DONE, ERR     status (DONE and ERR are sticky until the next GO)
//
// Configuration:
//   NOP_PAD_EN - when defined, PAD_WORDS zero words follow every program word.

module riscv_mem_loader #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 32,
    parameter int PAD_WORDS = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              GO,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_LAST,
    output logic              LOAD_PROGRAM_CTRL,
    output logic [ADDR_W-1:0] LOAD_PROGRAM_ADDR,
    output logic [DATA_W-1:0] LOAD_PROGRAM_DATA,
    output logic              LOAD_DATA_CTRL,
    output logic [ADDR_W-1:0] LOAD_DATA_ADDR,
    output logic [DATA_W-1:0] LOAD_DATA_DATA,
    output logic              CPU_RSTn,
    output logic              CPU_EN,
    output logic              CPU_START,
    input  logic              CPU_OK,
    output logic [CNT_W-1:0]  CYCLE_COUNT,
    output logic [ADDR_W:0]   PROG_WORDS,
    output logic [ADDR_W:0]   DATA_WORDS,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    // Pad words per program word. Zero makes the PAD state unreachable.
`ifdef NOP_PAD_EN
    localparam int PAD_N = PAD_WORDS;
`else
    localparam int PAD_N = 0;
`endif
    localparam int PAD_IW = (PAD_N > 1) ? $clog2(PAD_N) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_PROG,
        S_PAD,
        S_LOAD_DATA,
        S_FLUSH,    // last data write is on the port this cycle
        S_RELEASE,  // one idle cycle: no writes, core still in reset
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_prog_ctrl;
    logic [ADDR_W-1:0]   r_prog_addr;
    logic [DATA_W-1:0]   r_prog_data;
    logic                r_data_ctrl;
    logic [ADDR_W-1:0]   r_data_addr;
    logic [DATA_W-1:0]   r_data_data;
    logic                r_cpu_rstn;
    logic                r_cpu_en;
    logic                r_cpu_start;
    logic [CNT_W-1:0]    r_cycle_cnt;
    logic [ADDR_W:0]     r_prog_words;
    logic [ADDR_W:0]     r_data_words;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [PAD_IW-1:0]   r_pad_idx;
    logic                r_pad_last;

    logic w_accept;
    logic w_prog_full;
    logic w_data_full;

    assign w_accept    = IN_VALID & r_in_ready;
    // Word counters never exceed 2^ADDR_W, so the MSB alone means "segment full".
    assign w_prog_full = r_prog_words[ADDR_W];
    assign w_data_full = r_data_words[ADDR_W];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_prog_ctrl  <= 1'b0;
            r_prog_addr  <= '0;
            r_prog_data  <= '0;
            r_data_ctrl  <= 1'b0;
            r_data_addr  <= '0;
            r_data_data  <= '0;
            r_cpu_rstn   <= 1'b0;
            r_cpu_en     <= 1'b0;
            r_cpu_start  <= 1'b0;
            r_cycle_cnt  <= '0;
            r_prog_words <= '0;
            r_data_words <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_pad_idx    <= '0;
            r_pad_last   <= 1'b0;
        end else begin
            // Write enables are single-cycle pulses.
            r_prog_ctrl <= 1'b0;
            r_data_ctrl <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (GO) begin
                        r_state      <= S_LOAD_PROG;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_cycle_cnt  <= '0;
                        r_prog_words <= '0;
                        r_data_words <= '0;
                        r_cpu_rstn   <= 1'b0;
                        r_cpu_en     <= 1'b0;
                        r_cpu_start  <= 1'b0;
                    end
                end

                S_LOAD_PROG: begin
                    if (w_accept) begin
                        if (w_prog_full) begin
                            r_state    <= S_ERROR;
                            r_err      <= 1'b1;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_cpu_rstn <= 1'b0;
                        end else begin
                            r_prog_ctrl  <= 1'b1;
                            r_prog_addr  <= r_prog_words[ADDR_W-1:0];
                            r_prog_data  <= IN_DATA;
                            r_prog_words <= r_prog_words + (ADDR_W+1)'(1);
                            if (PAD_N != 0) begin
                                r_state    <= S_PAD;
                                r_in_ready <= 1'b0;
                                r_pad_idx  <= '0;
                                r_pad_last <= IN_LAST;
                            end else if (IN_LAST) begin
                                r_state <= S_LOAD_DATA;
                            end
                        end
                    end
                end

                S_PAD: begin
                    if (w_prog_full) begin
                        r_state    <= S_ERROR;
                        r_err      <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_cpu_rstn <= 1'b0;
                    end else begin
                        r_prog_ctrl  <= 1'b1;
                        r_prog_addr  <= r_prog_words[ADDR_W-1:0];
                        r_prog_data  <= '0;
                        r_prog_words <= r_prog_words + (ADDR_W+1)'(1);
                        if (r_pad_idx == PAD_IW'(PAD_N - 1)) begin
                            r_in_ready <= 1'b1;
                            r_state    <= r_pad_last ? S_LOAD_DATA : S_LOAD_PROG;
                        end else begin
                            r_pad_idx <= r_pad_idx + PAD_IW'(1);
                        end
                    end
                end

                S_LOAD_DATA: begin
                    if (w_accept) begin
                        if (w_data_full) begin
                            r_state    <= S_ERROR;
                            r_err      <= 1'b1;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_cpu_rstn <= 1'b0;
                        end else begin
                            r_data_ctrl  <= 1'b1;
                            r_data_addr  <= r_data_words[ADDR_W-1:0];
                            r_data_data  <= IN_DATA;
                            r_data_words <= r_data_words + (ADDR_W+1)'(1);
                            if (IN_LAST) begin
                                r_state    <= S_FLUSH;
                                r_in_ready <= 1'b0;
                            end
                        end
                    end
                end

                S_FLUSH: begin
                    r_state <= S_RELEASE;
                end

                S_RELEASE: begin
                    r_state     <= S_RUN;
                    r_cpu_rstn  <= 1'b1;
                    r_cpu_en    <= 1'b1;
                    r_cpu_start <= 1'b1;
                end

                S_RUN: begin
                    // The edge that samples CPU_OK high is still a run cycle.
                    if (r_cycle_cnt != {CNT_W{1'b1}}) begin
                        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                    end
                    if (CPU_OK) begin
                        r_state     <= S_DONE;
                        r_cpu_en    <= 1'b0;
                        r_cpu_start <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign IN_READY          = r_in_ready;
    assign LOAD_PROGRAM_CTRL = r_prog_ctrl;
    assign LOAD_PROGRAM_ADDR = r_prog_addr;
    assign LOAD_PROGRAM_DATA = r_prog_data;
    assign LOAD_DATA_CTRL    = r_data_ctrl;
    assign LOAD_DATA_ADDR    = r_data_addr;
    assign LOAD_DATA_DATA    = r_data_data;
    assign CPU_RSTn          = r_cpu_rstn;
    assign CPU_EN            = r_cpu_en;
    assign CPU_START         = r_cpu_start;
    assign CYCLE_COUNT       = r_cycle_cnt;
    assign PROG_WORDS        = r_prog_words;
    assign DATA_WORDS        = r_data_words;
    assign BUSY              = r_busy;
    assign DONE              = r_done;
    assign ERR               = r_err;

endmodule

// File: tb/tb_riscv_mem_loader.sv
// tb/tb_riscv_mem_loader.sv - directed self-checking bench for riscv_mem_loader

module tb_riscv_mem_loader;

`ifdef NOP_PAD_EN
    localparam int PADN = 3;
`else
    localparam int PADN = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid, in_last, cpu_ok;
    logic [31:0] in_data;
    logic        go_a, go_b, go_c;

    always #5 CLK = ~CLK;

    // instance a: default parameters
    logic a_ready, a_pc, a_dc, a_rstn, a_en, a_start, a_busy, a_done, a_err;
    logic [9:0]  a_pa, a_da;
    logic [31:0] a_pd, a_dd, a_cnt;
    logic [10:0] a_pw, a_dw;
    // instance b: ADDR_W = 3
    logic b_ready, b_pc, b_dc, b_rstn, b_en, b_start, b_busy, b_done, b_err;
    logic [2:0]  b_pa, b_da;
    logic [31:0] b_pd, b_dd, b_cnt;
    logic [3:0]  b_pw, b_dw;
    // instance c: CNT_W = 4
    logic c_ready, c_pc, c_dc, c_rstn, c_en, c_start, c_busy, c_done, c_err;
    logic [9:0]  c_pa, c_da;
    logic [31:0] c_pd, c_dd;
    logic [3:0]  c_cnt;
    logic [10:0] c_pw, c_dw;

    riscv_mem_loader u_a (
        .CLK(CLK), .RST(RST), .GO(go_a), .IN_VALID(in_valid), .IN_READY(a_ready),
        .IN_DATA(in_data), .IN_LAST(in_last),
        .LOAD_PROGRAM_CTRL(a_pc), .LOAD_PROGRAM_ADDR(a_pa), .LOAD_PROGRAM_DATA(a_pd),
        .LOAD_DATA_CTRL(a_dc), .LOAD_DATA_ADDR(a_da), .LOAD_DATA_DATA(a_dd),
        .CPU_RSTn(a_rstn), .CPU_EN(a_en), .CPU_START(a_start), .CPU_OK(cpu_ok),
        .CYCLE_COUNT(a_cnt), .PROG_WORDS(a_pw), .DATA_WORDS(a_dw),
        .BUSY(a_busy), .DONE(a_done), .ERR(a_err)
    );

    riscv_mem_loader #(.ADDR_W(3)) u_b (
        .CLK(CLK), .RST(RST), .GO(go_b), .IN_VALID(in_valid), .IN_READY(b_ready),
        .IN_DATA(in_data), .IN_LAST(in_last),
        .LOAD_PROGRAM_CTRL(b_pc), .LOAD_PROGRAM_ADDR(b_pa), .LOAD_PROGRAM_DATA(b_pd),
        .LOAD_DATA_CTRL(b_dc), .LOAD_DATA_ADDR(b_da), .LOAD_DATA_DATA(b_dd),
        .CPU_RSTn(b_rstn), .CPU_EN(b_en), .CPU_START(b_start), .CPU_OK(cpu_ok),
        .CYCLE_COUNT(b_cnt), .PROG_WORDS(b_pw), .DATA_WORDS(b_dw),
        .BUSY(b_busy), .DONE(b_done), .ERR(b_err)
    );

    riscv_mem_loader #(.CNT_W(4)) u_c (
        .CLK(CLK), .RST(RST), .GO(go_c), .IN_VALID(in_valid), .IN_READY(c_ready),
        .IN_DATA(in_data), .IN_LAST(in_last),
        .LOAD_PROGRAM_CTRL(c_pc), .LOAD_PROGRAM_ADDR(c_pa), .LOAD_PROGRAM_DATA(c_pd),
        .LOAD_DATA_CTRL(c_dc), .LOAD_DATA_ADDR(c_da), .LOAD_DATA_DATA(c_dd),
        .CPU_RSTn(c_rstn), .CPU_EN(c_en), .CPU_START(c_start), .CPU_OK(cpu_ok),
        .CYCLE_COUNT(c_cnt), .PROG_WORDS(c_pw), .DATA_WORDS(c_dw),
        .BUSY(c_busy), .DONE(c_done), .ERR(c_err)
    );

    int checks   = 0;
    int failures = 0;
    int sel      = 0;
    logic w_rdy, w_start;

    always_comb begin
        w_rdy   = a_ready;
        w_start = a_start;
        if (sel == 1) begin
            w_rdy = b_ready; w_start = b_start;
        end else if (sel == 2) begin
            w_rdy = c_ready; w_start = c_start;
        end
    end

    function automatic logic a_any();
        return |{a_ready, a_pc, a_pa, a_pd, a_dc, a_da, a_dd, a_rstn, a_en, a_start,
                 a_cnt, a_pw, a_dw, a_busy, a_done, a_err};
    endfunction

    // Monitor on instance a, sampled mid-cycle after the bench has driven inputs.
    int          cyc = 0;
    int          a_start_cyc = -1;
    logic        a_start_prev = 1'b0;
    logic [9:0]  pq_addr[$], dq_addr[$];
    logic [31:0] pq_data[$], dq_data[$];
    int          dq_cyc[$], acc_q[$];

    always begin
        @(negedge CLK);
        #2;
        cyc++;
        if (a_pc) begin pq_addr.push_back(a_pa); pq_data.push_back(a_pd); end
        if (a_dc) begin dq_addr.push_back(a_da); dq_data.push_back(a_dd); dq_cyc.push_back(cyc); end
        if (in_valid && a_ready) acc_q.push_back(cyc);
        if (a_start && !a_start_prev) a_start_cyc = cyc;
        a_start_prev = a_start;
    end

    task automatic clear_mon();
        pq_addr.delete(); pq_data.delete(); dq_addr.delete(); dq_data.delete();
        dq_cyc.delete(); acc_q.delete();
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [31:0] d, input logic l);
        int n;
        in_valid = 1'b1; in_data = d; in_last = l; n = 0;
        while (!w_rdy && n < 100) begin @(negedge CLK); n++; end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL send_timeout: ready=%0b required 1", w_rdy);
        end
        @(negedge CLK);
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    endtask

    task automatic pulse_go(input int which);
        go_a = (which == 0); go_b = (which == 1); go_c = (which == 2);
        @(negedge CLK);
        go_a = 1'b0; go_b = 1'b0; go_c = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!w_start && n < 200) begin @(negedge CLK); n++; end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL start_timeout: CPU_START=%0b required 1", w_start);
        end
    endtask

    task automatic finish_run();
        wait_start();
        cpu_ok = 1'b1;
        @(negedge CLK);
        cpu_ok = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (a_any() !== 1'b0) begin failures++; $display("FAIL reset_a_outputs: any=%0b required 0", a_any()); end
        checks++;
        if ({b_rstn, b_ready, b_busy, b_pw} !== 7'd0) begin failures++; $display("FAIL reset_b_outputs: got %b required 0", {b_rstn, b_ready, b_busy, b_pw}); end
        checks++;
        if (c_cnt !== 4'd0) begin failures++; $display("FAIL reset_c_count: got %0d required 0", c_cnt); end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (a_any() !== 1'b0) begin failures++; $display("FAIL idle_after_reset: any=%0b required 0", a_any()); end
    endtask

    task automatic test_basic();
        logic [31:0] pw[4];
        logic [31:0] dw[2];
        int np, gap;
        pw[0] = 32'h0000_0093; pw[1] = 32'h0010_0113; pw[2] = 32'h0020_8193; pw[3] = 32'h0000_006F;
        dw[0] = 32'hDEAD_BEEF; dw[1] = 32'h1234_5678;
        np = 4 * (1 + PADN);
        sel = 0;
        clear_mon();
        pulse_go(0);
        for (int i = 0; i < 4; i++) send(pw[i], i == 3);
        for (int i = 0; i < 2; i++) send(dw[i], i == 1);
        idle_in();
        wait_start();
        repeat (10) @(negedge CLK);
        cpu_ok = 1'b1;
        @(negedge CLK);
        cpu_ok = 1'b0;
        #3;
        checks++;
        if (a_cnt !== 32'd11) begin failures++; $display("FAIL basic_cycle_count: got %0d required 11", a_cnt); end
        checks++;
        if ({a_done, a_busy, a_en, a_start, a_rstn, a_err} !== 6'b100010) begin
            failures++; $display("FAIL basic_done_status: got %b required 100010", {a_done, a_busy, a_en, a_start, a_rstn, a_err});
        end
        checks++;
        if (a_pw !== 11'(np) || a_dw !== 11'd2) begin failures++; $display("FAIL basic_word_counts: got %0d/%0d required %0d/2", a_pw, a_dw, np); end
        checks++;
        if (pq_addr.size() != np) begin
            failures++; $display("FAIL basic_prog_writes: got %0d required %0d", pq_addr.size(), np);
        end else begin
            for (int i = 0; i < np; i++) begin
                logic [31:0] exp_d;
                exp_d = (i % (1 + PADN) == 0) ? pw[i / (1 + PADN)] : 32'd0;
                checks++;
                if (pq_addr[i] !== 10'(i) || pq_data[i] !== exp_d) begin
                    failures++; $display("FAIL basic_prog_word%0d: got %0d:%h required %0d:%h", i, pq_addr[i], pq_data[i], i, exp_d);
                end
            end
        end
        checks++;
        if (dq_addr.size() != 2) begin
            failures++; $display("FAIL basic_data_writes: got %0d required 2", dq_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dq_addr[i] !== 10'(i) || dq_data[i] !== dw[i]) begin
                    failures++; $display("FAIL basic_data_word%0d: got %0d:%h required %0d:%h", i, dq_addr[i], dq_data[i], i, dw[i]);
                end
            end
            gap = a_start_cyc - dq_cyc[1];
            checks++;
            if (gap != 2) begin failures++; $display("FAIL basic_release_gap: got %0d required 2", gap); end
        end
    endtask

    task automatic test_toggle();
        sel = 0;
        pulse_go(0);
        checks++;
        if ({a_done, a_err, a_busy} !== 3'b001) begin failures++; $display("FAIL toggle_restart_status: got %b required 001", {a_done, a_err, a_busy}); end
        send(32'h0000_0013, 1'b1);
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            send(32'hA000_0000 + 32'(i), i == 3);
            idle_in();
            @(negedge CLK);
        end
        #3;
        checks++;
        if (dq_addr.size() != 4 || acc_q.size() != 4) begin
            failures++; $display("FAIL toggle_write_count: got %0d writes %0d accepts required 4", dq_addr.size(), acc_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (dq_addr[i] !== 10'(i) || dq_data[i] !== 32'hA000_0000 + 32'(i) || dq_cyc[i] != acc_q[i] + 1) begin
                    failures++; $display("FAIL toggle_word%0d: got addr %0d data %h cyc %0d required %0d %h %0d",
                                         i, dq_addr[i], dq_data[i], dq_cyc[i], i, 32'hA000_0000 + 32'(i), acc_q[i] + 1);
                end
            end
        end
        finish_run();
    endtask

    task automatic test_overflow();
        int nb;
        nb = 8 / (1 + PADN);
        sel = 1;
        pulse_go(1);
        for (int i = 0; i < nb; i++) send(32'(i + 1), i == nb - 1);
        send(32'h55, 1'b1);
        idle_in();
        finish_run();
        checks++;
        if ({b_done, b_err} !== 2'b10 || b_pw !== 4'd8) begin
            failures++; $display("FAIL ovf_exact_fill: done/err %b words %0d required 10 and 8", {b_done, b_err}, b_pw);
        end
        pulse_go(1);
        for (int i = 0; i < nb; i++) send(32'(i + 1), 1'b0);
        send(32'h99, 1'b0);
        idle_in();
        checks++;
        if ({b_err, b_rstn, b_ready, b_pc, b_busy} !== 5'b10000) begin
            failures++; $display("FAIL ovf_error_state: err/rstn/ready/ctrl/busy %b required 10000", {b_err, b_rstn, b_ready, b_pc, b_busy});
        end
        checks++;
        if (b_pw !== 4'd8) begin failures++; $display("FAIL ovf_no_write: words %0d required 8", b_pw); end
        @(negedge CLK);
        checks++;
        if (b_pc !== 1'b0 || b_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky: ctrl %b err %b required 0 1", b_pc, b_err); end
    endtask

    task automatic test_rst();
        sel = 0;
        pulse_go(0);
        send(32'h0000_0013, 1'b1);
        send(32'hCAFE_0000, 1'b0);
        idle_in();
        #2 RST = 1'b1;
        #1;
        checks++;
        if (a_any() !== 1'b0) begin failures++; $display("FAIL rst_async_clear: any=%0b required 0", a_any()); end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        clear_mon();
        pulse_go(0);
        checks++;
        if ({a_done, a_err, a_busy, a_ready} !== 4'b0011) begin
            failures++; $display("FAIL rst_reload_status: got %b required 0011", {a_done, a_err, a_busy, a_ready});
        end
        send(32'h1111_2222, 1'b1);
        send(32'h3333_4444, 1'b1);
        idle_in();
        finish_run();
        checks++;
        if (pq_addr.size() == 0 || pq_addr[0] !== 10'd0 || pq_data[0] !== 32'h1111_2222) begin
            failures++; $display("FAIL rst_reload_addr: %0d writes, first at %0d required 0", pq_addr.size(), (pq_addr.size() > 0) ? int'(pq_addr[0]) : -1);
        end
    endtask

    task automatic test_saturate();
        sel = 2;
        pulse_go(2);
        send(32'h13, 1'b1);
        send(32'h77, 1'b1);
        idle_in();
        wait_start();
        repeat (20) @(negedge CLK);
        checks++;
        if (c_cnt !== 4'd15) begin failures++; $display("FAIL sat_count: got %0d required 15", c_cnt); end
        pulse_go(2);
        @(negedge CLK);
        checks++;
        if ({c_start, c_en, c_busy, c_done, c_cnt} !== {4'b1110, 4'd15}) begin
            failures++; $display("FAIL sat_go_ignored: got %b required 1110_1111", {c_start, c_en, c_busy, c_done, c_cnt});
        end
        cpu_ok = 1'b1;
        @(negedge CLK);
        cpu_ok = 1'b0;
        checks++;
        if (c_done !== 1'b1 || c_cnt !== 4'd15) begin failures++; $display("FAIL sat_done: done %b count %0d required 1 15", c_done, c_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        go_a = 1'b0; go_b = 1'b0; go_c = 1'b0; cpu_ok = 1'b0;
        idle_in();
        repeat (3) @(negedge CLK);
        test_reset();
        test_basic();
        test_toggle();
        test_overflow();
        test_rst();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
